// File: rtl/rvcpu_pkg.sv
// Shared rvcpu definitions: pipeline controller FSM states and default pipeline depth.
package rvcpu_pkg;

    localparam int DEFAULT_STAGES = 5;
    localparam int DRAIN_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_stall_resolve.sv
// Combinational stall/bubble/flush resolution for a linear pipeline of Stages stages.
module stall_resolve #(
    parameter int Stages = 5
) (
    input  logic [Stages-1:0] stallreq,
    input  logic [Stages-1:0] flushreq,
    output logic [Stages:0]   stall,
    output logic [Stages:0]   bubble,
    output logic              hold0,
    output logic              flush_accept
);

    logic [Stages-1:0] hold;
    int                flush_stage;

    // A stalled stage holds everything younger; the oldest unheld flush wins and clears the younger stages.
    always_comb begin
        hold         = '0;
        stall        = '0;
        bubble       = '0;
        flush_accept = 1'b0;
        flush_stage  = 0;

        hold[Stages-1] = stallreq[Stages-1];
        for (int i = Stages - 2; i >= 0; i--) begin
            hold[i] = hold[i+1] | stallreq[i];
        end

        for (int s = 0; s < Stages; s++) begin
            if (flushreq[s] && !hold[s]) begin
                flush_accept = 1'b1;
                flush_stage  = s;
            end
        end

        for (int i = 0; i < Stages; i++) begin
            stall[i] = hold[i];
        end
        for (int i = 1; i < Stages; i++) begin
            bubble[i] = hold[i-1] & ~hold[i];
        end
        bubble[Stages] = hold[Stages-1];

        if (flush_accept) begin
            for (int i = 0; i < Stages; i++) begin
                if (i <= flush_stage) begin
                    stall[i] = 1'b0;
                    if (i >= 1) begin
                        bubble[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign hold0 = hold[0];

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall/bubble generation plus RUN/DRAIN/HALTED sequencing.
// Performance counters are built only when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import rvcpu_pkg::*;
#(
    parameter int Stages   = DEFAULT_STAGES,
    parameter int CntWidth = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Stages-1:0]   stallreq,
    input  logic [Stages-1:0]   flushreq,
    input  logic                halt_req,
    input  logic                resume,
    output logic [Stages:0]     stall,
    output logic [Stages:0]     bubble,
    output logic                halted,
    output logic [CntWidth-1:0] cycles,
    output logic [CntWidth-1:0] stall_cycles,
    output logic [CntWidth-1:0] flush_count
);

    ctrl_state_t            state;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic [Stages:0]        run_stall;
    logic [Stages:0]        run_bubble;
    logic                   hold0;
    logic                   flush_accept;

    stall_resolve #(.Stages(Stages)) u_resolve (
        .stallreq     (stallreq),
        .flushreq     (flushreq),
        .stall        (run_stall),
        .bubble       (run_bubble),
        .hold0        (hold0),
        .flush_accept (flush_accept)
    );

    // While draining, the PC is frozen and IF feeds bubbles unless a flush redirects it.
    always_comb begin
        stall  = run_stall;
        bubble = run_bubble;
        if (state == ST_DRAIN) begin
            stall[0]  = ~flush_accept;
            bubble[1] = 1'b1;
        end else if (state == ST_HALTED) begin
            stall  = '1;
            bubble = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_CNT_W'(Stages);
                    end
                end
                ST_DRAIN: begin
                    if (!hold0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                        if (drain_cnt == DRAIN_CNT_W'(1)) begin
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    drain_cnt <= '0;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles       <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            cycles <= cycles + CntWidth'(1);
            if (state == ST_RUN && stall[0]) begin
                stall_cycles <= stall_cycles + CntWidth'(1);
            end
            if (flush_accept && state != ST_HALTED) begin
                flush_count <= flush_count + CntWidth'(1);
            end
        end
    end
`else
    assign cycles       = '0;
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (Stages=5, CntWidth=4); honours PIPELINE_CTRL_PERF_EN.
module tb_pipeline_ctrl;

    localparam int S      = 5;
    localparam int M_RUN  = 0;
    localparam int M_DRN  = 1;
    localparam int M_HLT  = 2;
`ifdef PIPELINE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [S-1:0] stallreq = '0;
    logic [S-1:0] flushreq = '0;
    logic         halt_req = 1'b0;
    logic         resume   = 1'b0;
    logic [S:0]   stall;
    logic [S:0]   bubble;
    logic         halted;
    logic [3:0]   cycles;
    logic [3:0]   stall_cycles;
    logic [3:0]   flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode = M_RUN;
    int m_left = 0;
    int m_cyc  = 0;
    int m_stc  = 0;
    int m_flc  = 0;

    pipeline_ctrl #(.Stages(S), .CntWidth(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq     (stallreq),
        .flushreq     (flushreq),
        .halt_req     (halt_req),
        .resume       (resume),
        .stall        (stall),
        .bubble       (bubble),
        .halted       (halted),
        .cycles       (cycles),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    // Index of the oldest stalling stage, -1 if none.
    function automatic int top_stall(input logic [S-1:0] sr);
        int t = -1;
        for (int i = 0; i < S; i++) if (sr[i]) t = i;
        return t;
    endfunction

    // Oldest flush older than every stall, -1 if none accepted.
    function automatic int flush_of(input logic [S-1:0] sr, input logic [S-1:0] fr);
        int t = top_stall(sr);
        int f = -1;
        for (int s = 0; s < S; s++) if (fr[s] && s > t) f = s;
        return f;
    endfunction

    function automatic logic [S:0] exp_stall(input int mode, input logic [S-1:0] sr, input logic [S-1:0] fr);
        int t = top_stall(sr);
        int f = flush_of(sr, fr);
        logic [S:0] v = '0;
        if (mode == M_HLT) return '1;
        if (f < 0 && t >= 0) v = (S+1)'((1 << (t + 1)) - 1);
        if (mode == M_DRN && f < 0) v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [S:0] exp_bubble(input int mode, input logic [S-1:0] sr, input logic [S-1:0] fr);
        int t = top_stall(sr);
        int f = flush_of(sr, fr);
        logic [S:0] v = '0;
        if (mode == M_HLT) return '0;
        if (f >= 0) v = (S+1)'((1 << (f + 1)) - 2);
        else if (t >= 0) v = (S+1)'(1 << (t + 1));
        if (mode == M_DRN) v[1] = 1'b1;
        return v;
    endfunction

    // Reference controller state, advanced on each clock edge outside reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= M_RUN;
            m_left <= 0;
            m_cyc  <= 0;
            m_stc  <= 0;
            m_flc  <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_mode == M_RUN && (exp_stall(M_RUN, stallreq, flushreq) & 6'd1) != 6'd0) m_stc <= m_stc + 1;
            if (m_mode != M_HLT && flush_of(stallreq, flushreq) >= 0) m_flc <= m_flc + 1;
            case (m_mode)
                M_RUN: if (halt_req) begin
                    m_mode <= M_DRN;
                    m_left <= S;
                end
                M_DRN: if (top_stall(stallreq) < 0) begin
                    m_left <= m_left - 1;
                    if (m_left - 1 == 0) m_mode <= M_HLT;
                end
                default: if (resume) m_mode <= M_RUN;
            endcase
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (stall !== exp_stall(m_mode, stallreq, flushreq) || bubble !== exp_bubble(m_mode, stallreq, flushreq)
            || halted !== (m_mode == M_HLT)) begin
            n_fail++;
            $display("[TB] FAIL model_outputs t=%0t: stall=%b bubble=%b halted=%b, expected stall=%b bubble=%b halted=%b",
                     $time, stall, bubble, halted, exp_stall(m_mode, stallreq, flushreq),
                     exp_bubble(m_mode, stallreq, flushreq), m_mode == M_HLT);
        end
        n_checks++;
        if (cycles !== 4'(PERF ? m_cyc : 0) || stall_cycles !== 4'(PERF ? m_stc : 0)
            || flush_count !== 4'(PERF ? m_flc : 0)) begin
            n_fail++;
            $display("[TB] FAIL model_counters t=%0t: got %0d/%0d/%0d, expected %0d/%0d/%0d", $time,
                     cycles, stall_cycles, flush_count, 4'(PERF ? m_cyc : 0), 4'(PERF ? m_stc : 0),
                     4'(PERF ? m_flc : 0));
        end
    end

    task automatic applyStimulus(input logic [S-1:0] sr, input logic [S-1:0] fr, input logic hr, input logic rs);
        @(posedge clk);
        #1;
        stallreq = sr;
        flushreq = fr;
        halt_req = hr;
        resume   = rs;
    endtask

    task automatic checkOutput(input string name, input logic [S:0] es, input logic [S:0] eb, input logic eh);
        #2;
        n_checks++;
        if (stall !== es || bubble !== eb || halted !== eh) begin
            n_fail++;
            $display("[TB] FAIL %s: stall=%b bubble=%b halted=%b, expected stall=%b bubble=%b halted=%b",
                     name, stall, bubble, halted, es, eb, eh);
        end
    endtask

    task automatic checkCounter(input string name, input logic [3:0] actual, input logic [3:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        #1;
        checkOutput("reset_outputs", 6'b000000, 6'b000000, 1'b0);
        checkCounter("reset_cycles", cycles, 4'd0);
        checkCounter("reset_flush_count", flush_count, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Combinational stall / bubble / flush priority in RUN
        applyStimulus(5'b00100, 5'b00000, 1'b0, 1'b0);
        checkOutput("stall_stage2", 6'b000111, 6'b001000, 1'b0);
        applyStimulus(5'b00000, 5'b00100, 1'b0, 1'b0);
        checkOutput("flush_stage2", 6'b000000, 6'b000110, 1'b0);
        applyStimulus(5'b01000, 5'b00100, 1'b0, 1'b0);
        checkOutput("flush_rejected", 6'b001111, 6'b010000, 1'b0);
        applyStimulus(5'b00000, 5'b10010, 1'b0, 1'b0);
        checkOutput("flush_oldest_wins", 6'b000000, 6'b011110, 1'b0);
        applyStimulus(5'b00100, 5'b10010, 1'b0, 1'b0);
        checkOutput("flush_above_stall", 6'b000000, 6'b011110, 1'b0);
        applyStimulus(5'b10000, 5'b00000, 1'b0, 1'b0);
        checkOutput("stall_oldest", 6'b011111, 6'b100000, 1'b0);
        applyStimulus(5'b00000, 5'b00001, 1'b0, 1'b0);
        checkOutput("flush_stage0", 6'b000000, 6'b000000, 1'b0);

        // Orderly drain with no stalls, halt, then resume
        applyStimulus(5'b00000, 5'b00000, 1'b1, 1'b1);
        checkOutput("halt_req_cycle", 6'b000000, 6'b000000, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0);
            checkOutput($sformatf("drain_cycle%0d", k), 6'b000001, 6'b000010, 1'b0);
        end
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0);
        checkOutput("halted_entry", 6'b111111, 6'b000000, 1'b1);
        applyStimulus(5'b00100, 5'b00010, 1'b1, 1'b1);
        checkOutput("halted_ignores_inputs", 6'b111111, 6'b000000, 1'b1);
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0);
        checkOutput("resumed_run", 6'b000000, 6'b000000, 1'b0);

        // Drain stretched by three IF stalls, with a redirect inside the drain
        applyStimulus(5'b00000, 5'b00000, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(5'b00011, 5'b00000, 1'b1, 1'b0);
            checkOutput($sformatf("drain_stalled%0d", k), 6'b000011, 6'b000110, 1'b0);
        end
        applyStimulus(5'b00000, 5'b00100, 1'b0, 1'b0);
        checkOutput("drain_flush", 6'b000000, 6'b000110, 1'b0);
        for (int k = 5; k <= 8; k++) begin
            applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0);
            checkOutput($sformatf("drain_late%0d", k), 6'b000001, 6'b000010, 1'b0);
        end
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b1);
        checkOutput("halted_delayed", 6'b111111, 6'b000000, 1'b1);
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0);
        checkOutput("resumed_again", 6'b000000, 6'b000000, 1'b0);

        // Asynchronous reset in the middle of a drain
        applyStimulus(5'b00000, 5'b00000, 1'b1, 1'b0);
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0);
        applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0);
        checkOutput("drain_before_rst", 6'b000001, 6'b000010, 1'b0);
        rst = 1'b1;
        checkOutput("rst_async_run", 6'b000000, 6'b000000, 1'b0);
        checkCounter("rst_async_cycles", cycles, 4'd0);
        checkCounter("rst_async_stall_cycles", stall_cycles, 4'd0);

        // Counter wrap and flush counting from a fresh reset
        @(posedge clk);
        #1;
        flushreq = 5'b00001;
        rst      = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            if (e == 2) flushreq = '0;
            if (e == 15) checkCounter("cycles_15", cycles, PERF ? 4'd15 : 4'd0);
        end
        checkCounter("cycles_wrap", cycles, 4'd0);
        checkCounter("flush_count_2", flush_count, PERF ? 4'd2 : 4'd0);
        checkCounter("stall_cycles_0", stall_cycles, 4'd0);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
